uart_mem_com_core: RTL and testbench

Byte-serial vector co-processor. Receives two 32-bit operand vectors over a UART (8N1) into on-chip memory, adds them element-wise on command, and streams the result vector back over the UART. The host sequences it through three phases (receive, compute, send) using mode inputs and a reset pulse between phases. It instantiates `uart_rx` and `uart_tx` with the same `CLKS_PER_BIT`.

---
 rtl/uart_mem_com_core_if.sv | 24 ++
 rtl/uart_mem_com_core.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_uart_mem_com_core.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_com_core_if.sv
// uart_mem_com_core_if: host-side mode controls, status flags and UART serial lines.
// Revision 1.0
`default_nettype none

interface uart_mem_com_core_if;
   logic mem2uart;
   logic COM;
   logic Rx_Serial;
   logic recv_done;
   logic send_done;
   logic Tx_Serial;

   modport master (
      output mem2uart, COM, Rx_Serial,
      input  recv_done, send_done, Tx_Serial
   );

   modport slave (
      input  mem2uart, COM, Rx_Serial,
      output recv_done, send_done, Tx_Serial
   );
endinterface

`default_nettype wire

// File: rtl/uart_mem_com_core.sv
// uart_mem_com_core: UART-fed vector adder (receive A|B, compute R=A+B, stream R back).
// Optional macro UMC_SATURATE_EN selects unsigned saturating add.  Revision 1.0
`default_nettype none

module uart_rx #(
   parameter logic [15:0] CLKS_PER_BIT = 16'd100
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_Rx_Serial,
   output logic            o_Rx_DV,
   output logic [7:0]      o_Rx_Byte
);
   localparam logic [15:0] HALF = (CLKS_PER_BIT - 16'd1) >> 1;
   localparam logic [15:0] LAST = CLKS_PER_BIT - 16'd1;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t   state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [7:0]  shreg, shreg_n;
   logic        dv_n;
   logic        rx_meta, rx_sync;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      dv_n      = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_n     = '0;
            bit_idx_n = '0;
            if (!rx_sync) state_n = RX_START;
         end
         RX_START: begin
            // A start bit that is no longer low at mid-bit is treated as a glitch.
            if (cnt == HALF) begin
               cnt_n   = '0;
               state_n = rx_sync ? RX_IDLE : RX_DATA;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         RX_DATA: begin
            if (cnt == LAST) begin
               cnt_n   = '0;
               shreg_n = {rx_sync, shreg[7:1]};
               if (bit_idx == 3'd7) state_n = RX_STOP;
               else                 bit_idx_n = bit_idx + 3'd1;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         RX_STOP: begin
            if (cnt == LAST) begin
               cnt_n   = '0;
               dv_n    = 1'b1;
               state_n = RX_IDLE;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         o_Rx_DV <= 1'b0;
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
         o_Rx_DV <= dv_n;
         rx_meta <= i_Rx_Serial;
         rx_sync <= rx_meta;
      end
   end

   assign o_Rx_Byte = shreg;
endmodule

module uart_tx #(
   parameter logic [15:0] CLKS_PER_BIT = 16'd100
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_Tx_DV,
   input  wire logic [7:0] i_Tx_Byte,
   output logic            o_Tx_Serial,
   output logic            o_Tx_Done
);
   localparam logic [15:0] LAST = CLKS_PER_BIT - 16'd1;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t   state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [7:0]  shreg, shreg_n;
   logic        serial_n, done_n;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      serial_n  = o_Tx_Serial;
      done_n    = 1'b0;
      case (state)
         TX_IDLE: begin
            cnt_n     = '0;
            bit_idx_n = '0;
            serial_n  = 1'b1;
            if (i_Tx_DV) begin
               shreg_n  = i_Tx_Byte;
               serial_n = 1'b0;
               state_n  = TX_START;
            end
         end
         TX_START: begin
            if (cnt == LAST) begin
               cnt_n    = '0;
               serial_n = shreg[0];
               state_n  = TX_DATA;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         TX_DATA: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  serial_n = 1'b1;
                  state_n  = TX_STOP;
               end else begin
                  shreg_n   = {1'b0, shreg[7:1]};
                  serial_n  = shreg[1];
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         TX_STOP: begin
            if (cnt == LAST) begin
               cnt_n   = '0;
               done_n  = 1'b1;
               state_n = TX_IDLE;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: state_n = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= TX_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         o_Tx_Serial <= 1'b1;
         o_Tx_Done   <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         bit_idx     <= bit_idx_n;
         shreg       <= shreg_n;
         o_Tx_Serial <= serial_n;
         o_Tx_Done   <= done_n;
      end
   end
endmodule

module uart_mem_com_core #(
   parameter logic [15:0] CLKS_PER_BIT = 16'd100,
   parameter int          MEM_SIZE     = 512
) (
   input  wire logic          clk,
   input  wire logic          rst,
   uart_mem_com_core_if.slave bus
);
   // MEM_SIZE is expected to be a power of two, at least 2 and at most 1024.
   localparam int          RES_AW    = $clog2(MEM_SIZE);
   localparam int          OP_AW     = RES_AW + 1;
   localparam logic [12:0] RECV_LAST = 13'(8 * MEM_SIZE - 1);
   localparam logic [12:0] SEND_LAST = 13'(4 * MEM_SIZE - 1);
   localparam logic [RES_AW-1:0] IDX_LAST = RES_AW'(MEM_SIZE - 1);

   typedef enum logic [2:0] {IDLE, RECV, COMP, SEND, DONE} state_t;

   state_t            state, state_n;
   logic [12:0]       byte_cnt, byte_cnt_n;
   logic [RES_AW-1:0] elem_idx, elem_idx_n;
   logic              recv_flag, recv_flag_n;
   logic              send_flag, send_flag_n;
   logic              tx_wait, tx_wait_n;
   logic              tx_dv, op_we, res_we;

   logic              rx_dv;
   logic [7:0]        rx_byte;
   logic              tx_done;
   logic [7:0]        tx_byte;

   logic [31:0]       op_mem  [2*MEM_SIZE];
   logic [31:0]       res_mem [MEM_SIZE];
   logic [31:0]       opnd_a, opnd_b, sum, res_word;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk         (clk),
      .rst         (rst),
      .i_Rx_Serial (bus.Rx_Serial),
      .o_Rx_DV     (rx_dv),
      .o_Rx_Byte   (rx_byte)
   );

   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk         (clk),
      .rst         (rst),
      .i_Tx_DV     (tx_dv),
      .i_Tx_Byte   (tx_byte),
      .o_Tx_Serial (bus.Tx_Serial),
      .o_Tx_Done   (tx_done)
   );

   assign opnd_a = op_mem[{1'b0, elem_idx}];
   assign opnd_b = op_mem[{1'b1, elem_idx}];

`ifdef UMC_SATURATE_EN
   logic [32:0] sum_wide;
   assign sum_wide = {1'b0, opnd_a} + {1'b0, opnd_b};
   assign sum      = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
`else
   assign sum = opnd_a + opnd_b;
`endif

   assign res_word = res_mem[byte_cnt[RES_AW+1:2]];
   assign tx_byte  = res_word[{byte_cnt[1:0], 3'b000} +: 8];

   always_comb begin
      state_n     = state;
      byte_cnt_n  = byte_cnt;
      elem_idx_n  = elem_idx;
      recv_flag_n = recv_flag;
      send_flag_n = send_flag;
      tx_wait_n   = tx_wait;
      tx_dv       = 1'b0;
      op_we       = 1'b0;
      res_we      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.mem2uart)  state_n = SEND;
            else if (bus.COM)  state_n = COMP;
            else               state_n = RECV;
         end
         RECV: begin
            if (rx_dv) begin
               op_we = 1'b1;
               if (byte_cnt == RECV_LAST) begin
                  recv_flag_n = 1'b1;
                  state_n     = DONE;
               end else begin
                  byte_cnt_n = byte_cnt + 13'd1;
               end
            end
         end
         COMP: begin
            res_we = 1'b1;
            if (elem_idx == IDX_LAST) begin
               recv_flag_n = 1'b1;
               state_n     = DONE;
            end else begin
               elem_idx_n = elem_idx + 1'b1;
            end
         end
         SEND: begin
            // One byte in flight at a time; the next is loaded after o_Tx_Done.
            if (!tx_wait) begin
               tx_dv     = 1'b1;
               tx_wait_n = 1'b1;
            end else if (tx_done) begin
               if (byte_cnt == SEND_LAST) begin
                  send_flag_n = 1'b1;
                  state_n     = DONE;
               end else begin
                  byte_cnt_n = byte_cnt + 13'd1;
                  tx_wait_n  = 1'b0;
               end
            end
         end
         DONE:    state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         byte_cnt  <= '0;
         elem_idx  <= '0;
         recv_flag <= 1'b0;
         send_flag <= 1'b0;
         tx_wait   <= 1'b0;
      end else begin
         state     <= state_n;
         byte_cnt  <= byte_cnt_n;
         elem_idx  <= elem_idx_n;
         recv_flag <= recv_flag_n;
         send_flag <= send_flag_n;
         tx_wait   <= tx_wait_n;
      end
   end

   // Memories are not reset so a reset between phases keeps the data.
   always_ff @(posedge clk) begin
      if (op_we)
         op_mem[byte_cnt[OP_AW+1:2]][{byte_cnt[1:0], 3'b000} +: 8] <= rx_byte;
      if (res_we)
         res_mem[elem_idx] <= sum;
   end

   assign bus.recv_done = recv_flag;
   assign bus.send_done = send_flag;
endmodule

`default_nettype wire

// File: tb/tb_uart_mem_com_core.sv
// tb_uart_mem_com_core: directed receive/compute/send flow on a small core instance.
// Revision 1.0
`default_nettype none

module tb_uart_mem_com_core;
   localparam int MS  = 4;
   localparam int CPB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_mem_com_core_if bus ();

   uart_mem_com_core #(.CLKS_PER_BIT(16'(CPB)), .MEM_SIZE(MS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.Rx_Serial = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.Rx_Serial = b[i];
         repeat (CPB) @(negedge clk);
      end
      bus.Rx_Serial = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   // Waits up to 'bound' cycles for a start bit, then samples each bit at mid-bit.
   task automatic recv_byte(input int bound, output logic [7:0] b, output logic ok);
      ok = 1'b0;
      b  = 8'h00;
      for (int c = 0; c < bound; c++) begin
         @(negedge clk);
         if (bus.Tx_Serial === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         repeat (CPB/2) @(negedge clk);
         if (bus.Tx_Serial !== 1'b0) ok = 1'b0;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = bus.Tx_Serial;
         end
         repeat (CPB) @(negedge clk);
         if (bus.Tx_Serial !== 1'b1) ok = 1'b0;
      end
   endtask

   task automatic pulse_rst(input logic m2u, input logic com);
      @(negedge clk);
      rst = 1'b1;
      bus.mem2uart = m2u;
      bus.COM      = com;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   logic [31:0] vec_a [MS];
   logic [31:0] vec_b [MS];
   logic [31:0] exp_r [MS];
   logic [7:0]  stream [8*MS];

   initial begin
      logic        rd_seen, sd_seen, tx_low;
      logic        ok, seen;
      logic [7:0]  b;
      logic [31:0] word;
      int          bound;

      bus.Rx_Serial = 1'b1;
      bus.mem2uart  = 1'b0;
      bus.COM       = 1'b0;

      vec_a[0] = 32'hFFFF_FFFF; vec_b[0] = 32'h0000_0002;
      vec_a[1] = 32'h0000_0001; vec_b[1] = 32'h0000_0100;
      vec_a[2] = 32'h0000_0002; vec_b[2] = 32'h0000_0200;
      vec_a[3] = 32'h0000_0003; vec_b[3] = 32'h0000_0300;
`ifdef UMC_SATURATE_EN
      exp_r[0] = 32'hFFFF_FFFF;
`else
      exp_r[0] = 32'h0000_0001;
`endif
      exp_r[1] = 32'h0000_0101;
      exp_r[2] = 32'h0000_0202;
      exp_r[3] = 32'h0000_0303;
      for (int w = 0; w < MS; w++) begin
         for (int l = 0; l < 4; l++) begin
            word = vec_a[w];
            stream[4*w + l] = word[8*l +: 8];
            word = vec_b[w];
            stream[4*(MS + w) + l] = word[8*l +: 8];
         end
      end

      // Reset held: outputs stay at their reset values.
      repeat (2) @(negedge clk);
      rd_seen = 1'b0; sd_seen = 1'b0; tx_low = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.recv_done !== 1'b0) rd_seen = 1'b1;
         if (bus.send_done !== 1'b0) sd_seen = 1'b1;
         if (bus.Tx_Serial !== 1'b1) tx_low  = 1'b1;
      end
      check("rst_recv_done", {31'b0, rd_seen}, 32'd0);
      check("rst_send_done", {31'b0, sd_seen}, 32'd0);
      check("rst_tx_high",   {31'b0, tx_low},  32'd0);
      rst = 1'b0;

      // Partial receive, then an aborting reset.
      for (int k = 0; k < 5; k++) send_byte(8'hAA);
      check("partial_recv_done", {31'b0, bus.recv_done}, 32'd0);
      pulse_rst(1'b0, 1'b0);
      @(negedge clk);
      check("abort_recv_done", {31'b0, bus.recv_done}, 32'd0);

      for (int k = 0; k < 8*MS - 1; k++) send_byte(stream[k]);
      check("recv_done_early", {31'b0, bus.recv_done}, 32'd0);
      send_byte(stream[8*MS - 1]);
      repeat (2) @(negedge clk);
      check("recv_done_set", {31'b0, bus.recv_done}, 32'd1);

      // Surplus bytes must not wrap into vector A.
      for (int k = 0; k < 4; k++) send_byte(8'h55);
      check("recv_done_held", {31'b0, bus.recv_done}, 32'd1);

      // Compute, then feed bytes while in the compute phase and compute again.
      for (int pass = 0; pass < 2; pass++) begin
         pulse_rst(1'b0, 1'b1);
         check($sformatf("comp%0d_start", pass), {31'b0, bus.recv_done}, 32'd0);
         seen = 1'b0;
         for (int c = 0; c < MS + 2; c++) begin
            @(negedge clk);
            if (bus.recv_done === 1'b1) begin
               seen = 1'b1;
               break;
            end
         end
         check($sformatf("comp%0d_done", pass), {31'b0, seen}, 32'd1);
         if (pass == 0)
            for (int k = 0; k < 4; k++) send_byte(8'h77);
      end

      // Send phase: mem2uart takes priority over COM.
      pulse_rst(1'b1, 1'b1);
      for (int w = 0; w < MS; w++) begin
         word = 32'h0;
         for (int l = 0; l < 4; l++) begin
            bound = (w == 0 && l == 0) ? 4 : CPB/2 + 3;
            recv_byte(bound, b, ok);
            check($sformatf("tx_frame_%0d", 4*w + l), {31'b0, ok}, 32'd1);
            word[8*l +: 8] = b;
         end
         check($sformatf("res_word_%0d", w), word, exp_r[w]);
         if (w == 0)
            check("send_done_mid", {31'b0, bus.send_done}, 32'd0);
      end
      repeat (CPB) @(negedge clk);
      check("send_done_set", {31'b0, bus.send_done}, 32'd1);
      tx_low = 1'b0;
      for (int c = 0; c < 4*CPB; c++) begin
         @(negedge clk);
         if (bus.Tx_Serial !== 1'b1) tx_low = 1'b1;
      end
      check("tx_idle_after", {31'b0, tx_low}, 32'd0);
      check("send_done_held", {31'b0, bus.send_done}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
